exec_branch: RTL and testbench

Branch-condition resolver on the consumer side of the compare flags. Holds the architectural flag register written by the compare unit as {overflow, sign, zero, carry}. Evaluates a 4-bit condition code for each conditional branch and returns a registered taken/target result over a valid/ready handshake to the fetch-redirect logic.

---
 rtl/exec_branch_pkg.sv | 38 +++
 rtl/exec_cond_eval.sv | 43 ++++
 rtl/exec_branch.sv | 99 +++++++++
 tb/tb_exec_branch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_branch_pkg.sv
// Shared types and constants for the branch resolver: flag layout {V,S,Z,C},
// condition-code encoding and output-stage state encoding.
package exec_branch_pkg;

  localparam int W_ADDR     = 32;
  localparam int W_FLAGS    = 4;
  localparam int INSN_BYTES = 4;

  localparam int FLAG_V = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    COND_EQ  = 4'd0,
    COND_NE  = 4'd1,
    COND_LTU = 4'd2,
    COND_GEU = 4'd3,
    COND_LT  = 4'd4,
    COND_GE  = 4'd5,
    COND_LE  = 4'd6,
    COND_GT  = 4'd7,
    COND_LEU = 4'd8,
    COND_GTU = 4'd9,
    COND_MI  = 4'd10,
    COND_PL  = 4'd11,
    COND_VS  = 4'd12,
    COND_VC  = 4'd13,
    COND_AL  = 4'd14,
    COND_NV  = 4'd15
  } cond_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/exec_cond_eval.sv
// Combinational condition-code evaluator (flags, cond -> taken); shared by the
// branch resolver and usable for conditional moves.
module exec_cond_eval
  import exec_branch_pkg::*;
(
  input  logic [W_FLAGS-1:0] flags_i,
  input  logic [3:0]         cond_i,
  output logic               taken_o
);

  logic v, s, z, c, lt;

  assign v  = flags_i[FLAG_V];
  assign s  = flags_i[FLAG_S];
  assign z  = flags_i[FLAG_Z];
  assign c  = flags_i[FLAG_C];
  // C is a borrow, so LTU is C directly rather than ~C.
  assign lt = s ^ v;

  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ:  taken_o = z;
      COND_NE:  taken_o = ~z;
      COND_LTU: taken_o = c;
      COND_GEU: taken_o = ~c;
      COND_LT:  taken_o = lt;
      COND_GE:  taken_o = ~lt;
      COND_LE:  taken_o = z | lt;
      COND_GT:  taken_o = ~z & ~lt;
      COND_LEU: taken_o = c | z;
      COND_GTU: taken_o = ~c & ~z;
      COND_MI:  taken_o = s;
      COND_PL:  taken_o = ~s;
      COND_VS:  taken_o = v;
      COND_VC:  taken_o = ~v;
      COND_AL:  taken_o = 1'b1;
      COND_NV:  taken_o = 1'b0;
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_branch.sv
// Branch-condition resolver: flag register plus a one-entry registered result stage.
// EXEC_BRANCH_FLAG_BYPASS_EN forwards same-cycle flag writes instead of stalling.
//   state    | meaning
//   ST_EMPTY | no result held, res_valid_o low
//   ST_FULL  | result held until res_ready_i or flush_i
module exec_branch
  import exec_branch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flags_we_i,
  input  logic [W_FLAGS-1:0] flags_i,
  output logic [W_FLAGS-1:0] flags_o,
  input  logic               br_valid_i,
  output logic               br_ready_o,
  input  logic [3:0]         br_cond_i,
  input  logic [W_ADDR-1:0]  br_pc_i,
  input  logic [W_ADDR-1:0]  br_off_i,
  input  logic               flush_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic               res_taken_o,
  output logic [W_ADDR-1:0]  res_target_o
);

  res_state_e          state_q, state_d;
  logic [W_FLAGS-1:0]  flags_q;
  logic [W_FLAGS-1:0]  eval_flags;
  logic                taken_q, taken_d;
  logic [W_ADDR-1:0]   target_q, target_d;
  logic                stall;
  logic                cond_taken;
  logic                accept;
  logic [W_ADDR-1:0]   target_taken;
  logic [W_ADDR-1:0]   target_fall;

`ifdef EXEC_BRANCH_FLAG_BYPASS_EN
  assign eval_flags = flags_we_i ? flags_i : flags_q;
  assign stall      = 1'b0;
`else
  // Without forwarding, hold the branch one cycle so it sees the new flags.
  assign eval_flags = flags_q;
  assign stall      = flags_we_i & br_valid_i;
`endif

  exec_cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .cond_i  (br_cond_i),
    .taken_o (cond_taken)
  );

  assign target_taken = br_pc_i + br_off_i;
  assign target_fall  = br_pc_i + W_ADDR'(INSN_BYTES);

  assign res_valid_o  = (state_q == ST_FULL);
  assign br_ready_o   = ~flush_i & (~res_valid_o | res_ready_i) & ~stall;
  assign accept       = br_valid_i & br_ready_o;

  assign flags_o      = flags_q;
  assign res_taken_o  = taken_q;
  assign res_target_o = target_q;

  always_comb begin
    state_d  = state_q;
    taken_d  = taken_q;
    target_d = target_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d  = ST_FULL;
      taken_d  = cond_taken;
      target_d = cond_taken ? target_taken : target_fall;
    end else if (res_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_EMPTY;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  // Flag register ignores the handshake and flush entirely.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_q <= '0;
    end else if (flags_we_i) begin
      flags_q <= flags_i;
    end
  end

endmodule

// File: tb/tb_exec_branch.sv
// Scoreboard bench for exec_branch: directed scenarios then randomized traffic,
// checked against a condition-table reference model.
module tb_exec_branch;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flags_we_i;
  logic [3:0]  flags_i;
  logic [3:0]  flags_o;
  logic        br_valid_i;
  logic        br_ready_o;
  logic [3:0]  br_cond_i;
  logic [31:0] br_pc_i;
  logic [31:0] br_off_i;
  logic        flush_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_taken_o;
  logic [31:0] res_target_o;

  always #5 clk_i = ~clk_i;

  exec_branch dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flags_we_i   (flags_we_i),
    .flags_i      (flags_i),
    .flags_o      (flags_o),
    .br_valid_i   (br_valid_i),
    .br_ready_o   (br_ready_o),
    .br_cond_i    (br_cond_i),
    .br_pc_i      (br_pc_i),
    .br_off_i     (br_off_i),
    .flush_i      (flush_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_taken_o  (res_taken_o),
    .res_target_o (res_target_o)
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  logic        m_valid;
  logic [3:0]  m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Odd codes are the negation of the even code below them; pairs share a base test.
  function automatic logic ref_taken(input logic [3:0] f, input logic [3:0] cc);
    logic v, s, z, c, base;
    v = f[3]; s = f[2]; z = f[1]; c = f[0];
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = s ^ v;
      3'd3:    base = z | (s ^ v);
      3'd4:    base = c | z;
      3'd5:    base = s;
      3'd6:    base = v;
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  // Monitor: compares presented results against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_n_i) begin
        chk("res_valid", 32'(res_valid_o), 32'(exp_q.size() != 0));
        if (res_valid_o && exp_q.size() != 0) begin
          chk("res_taken", 32'(res_taken_o), 32'(exp_q[0].taken));
          chk("res_target", res_target_o, exp_q[0].target);
          if (res_ready_i && !flush_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Reference model: predicts ready, tracks flags, pushes expected results on accept.
  initial begin
    forever begin
      logic exp_stall, exp_ready, acc, tk;
      logic [3:0] ef;
      exp_t e;
      @(negedge clk_i);
      #2;
      if (!rst_n_i) begin
        exp_q.delete();
        m_valid = 1'b0;
        m_flags = 4'h0;
      end else begin
`ifdef EXEC_BRANCH_FLAG_BYPASS_EN
        exp_stall = 1'b0;
        ef        = flags_we_i ? flags_i : m_flags;
`else
        exp_stall = flags_we_i && br_valid_i;
        ef        = m_flags;
`endif
        exp_ready = !flush_i && (!m_valid || res_ready_i) && !exp_stall;
        chk("br_ready", 32'(br_ready_o), 32'(exp_ready));
        chk("flags_o", 32'(flags_o), 32'(m_flags));
        acc = br_valid_i && exp_ready;
        if (flush_i && m_valid && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
          tk       = ref_taken(ef, br_cond_i);
          e.taken  = tk;
          e.target = tk ? br_pc_i + br_off_i : br_pc_i + 32'd4;
          exp_q.push_back(e);
        end
        if (flush_i)                      m_valid = 1'b0;
        else if (acc)                     m_valid = 1'b1;
        else if (m_valid && res_ready_i)  m_valid = 1'b0;
        if (flags_we_i) m_flags = flags_i;
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] f, input logic v,
                       input logic [3:0] cc, input logic [31:0] pc, input logic [31:0] off,
                       input logic fl, input logic rr);
    @(negedge clk_i);
    flags_we_i  = we;
    flags_i     = f;
    br_valid_i  = v;
    br_cond_i   = cc;
    br_pc_i     = pc;
    br_off_i    = off;
    flush_i     = fl;
    res_ready_i = rr;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    flags_we_i  = 1'b0;
    flags_i     = 4'h0;
    br_valid_i  = 1'b0;
    br_cond_i   = 4'h0;
    br_pc_i     = 32'h0;
    br_off_i    = 32'h0;
    flush_i     = 1'b0;
    res_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #3;
    chk("rst_flags", 32'(flags_o), 32'h0);
    chk("rst_res_valid", 32'(res_valid_o), 32'h0);
    chk("rst_res_taken", 32'(res_taken_o), 32'h0);
    chk("rst_res_target", res_target_o, 32'h0);
    chk("rst_br_ready", 32'(br_ready_o), 32'h1);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // EQ taken with Z set
    drive(1, 4'b0010, 0, 4'd0, 0, 0, 0, 1);
    drive(0, 4'b0000, 1, 4'd0, 32'h100, 32'h40, 0, 1);
    // GEU then LTU back-to-back with C set
    drive(1, 4'b0001, 0, 4'd0, 0, 0, 0, 1);
    drive(0, 4'b0000, 1, 4'd3, 32'h200, 32'h10, 0, 1);
    drive(0, 4'b0000, 1, 4'd2, 32'h300, 32'h20, 0, 1);
    // Signed compares with S^V = 1
    drive(1, 4'b1000, 0, 4'd0, 0, 0, 0, 1);
    for (int k = 4; k < 8; k++) drive(0, 4'b0000, 1, 4'(k), 32'h400 + 32'(k), 32'h80, 0, 1);
    // Backpressure: result held for three cycles, then release with a new accept
    drive(0, 4'b0000, 1, 4'd14, 32'h500, 32'h8, 0, 0);
    repeat (3) drive(0, 4'b0000, 1, 4'd15, 32'h600, 32'h8, 0, 0);
    drive(0, 4'b0000, 1, 4'd15, 32'h600, 32'h8, 0, 1);
    drive(0, 4'b0000, 0, 4'd0, 0, 0, 0, 1);
    // Flag write and NE branch in the same cycle
    drive(1, 4'b0010, 1, 4'd1, 32'h700, 32'h100, 0, 1);
    drive(0, 4'b0000, 1, 4'd1, 32'h700, 32'h100, 0, 1);
    drive(0, 4'b0000, 0, 4'd0, 0, 0, 0, 1);
    // Wrap-around target, then flush of the pending result
    drive(0, 4'b0000, 1, 4'd14, 32'hFFFF_FFF0, 32'h20, 0, 0);
    drive(0, 4'b0000, 1, 4'd14, 32'h800, 32'h4, 1, 1);
    drive(0, 4'b0000, 0, 4'd0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      rst_n_i     = (i != 1500);
      flags_we_i  = ($urandom_range(3, 0) == 0);
      flags_i     = 4'($urandom);
      br_valid_i  = ($urandom_range(9, 0) < 7);
      br_cond_i   = 4'($urandom);
      br_pc_i     = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(255, 0)) : $urandom;
      br_off_i    = ($urandom_range(1, 0) == 0) ? 32'($urandom_range(4095, 0)) : $urandom;
      flush_i     = ($urandom_range(9, 0) == 0);
      res_ready_i = ($urandom_range(9, 0) < 7);
    end

    repeat (3) drive(0, 4'b0000, 0, 4'd0, 0, 0, 0, 1);
    @(negedge clk_i);
    #5;
    chk("drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
